// File: rtl/nmcu_pkg.sv
// Shared NMCU types and sizing constants for the memory request path.
package nmcu_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned LEN_WIDTH      = 8;
    localparam int unsigned MEM_SIZE_WORDS = 16384;
    localparam int unsigned MEM_LATENCY    = 5;

    // Request from the NMCU towards main memory (74 bits).
    typedef struct packed {
        logic                  valid;
        logic                  write_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [LEN_WIDTH-1:0]  len;
    } mem_req_t;

    // Response beat from main memory (66 bits).
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  hit;
    } mem_resp_t;

endpackage : nmcu_pkg

// File: rtl/nmcu_mem_model.sv
// Fixed-latency, word-addressed main memory: one request at a time,
// read bursts of len words, single-word writes, no backpressure on beats.
module nmcu_mem_model
    import nmcu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_SIZE_WORDS,
    parameter int unsigned LATENCY   = MEM_LATENCY
) (
    input  logic      clk,
    input  logic      rst_n,
    input  mem_req_t  req_i,
    output logic      req_ready_o,
    output mem_resp_t resp_o,
    output logic      busy_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t                 state;
    logic                   wr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [IDX_W-1:0]       base_idx_q;
    logic [IDX_W-1:0]       cur_idx_q;
    logic [ADDR_WIDTH-1:0]  cur_addr_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]       wait_cnt_q;

    logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];

    logic [IDX_W-1:0]       req_idx_c;
    logic [LEN_WIDTH-1:0]   req_beats_c;
    logic                   accept_c;
    logic [DATA_WIDTH-1:0]  beat_rdata_c;
    logic                   unused_addr_c;

    // Request decode: word index wraps modulo MEM_WORDS; writes are one beat.
    always_comb begin
        req_idx_c     = req_i.addr[2 +: IDX_W];
        req_beats_c   = (req_i.write_en || (req_i.len == '0)) ? LEN_WIDTH'(1) : req_i.len;
        accept_c      = req_i.valid && req_ready_o;
        beat_rdata_c  = wr_q ? wdata_q : mem[cur_idx_q];
        unused_addr_c = ^{req_i.addr[ADDR_WIDTH-1:2+IDX_W], req_i.addr[1:0]};
    end

    // Control FSM; every response field is registered and held between beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            resp_o      <= '0;
            wait_cnt_q  <= '0;
            rem_q       <= '0;
            wr_q        <= 1'b0;
        end else begin
            resp_o.valid <= 1'b0;
            resp_o.hit   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        wr_q        <= req_i.write_en;
                        wdata_q     <= req_i.wdata;
                        base_idx_q  <= req_idx_c;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (LATENCY == 1) begin
                            // Zero wait cycles: the first beat launches on the accept edge.
                            state        <= S_BURST;
                            resp_o.valid <= 1'b1;
                            resp_o.addr  <= req_i.addr;
                            resp_o.rdata <= req_i.write_en ? req_i.wdata : mem[req_idx_c];
                            cur_addr_q   <= req_i.addr + 32'd4;
                            cur_idx_q    <= req_idx_c + IDX_W'(1);
                            rem_q        <= req_beats_c - LEN_WIDTH'(1);
                        end else begin
                            state      <= S_WAIT;
                            wait_cnt_q <= CNT_W'(LATENCY - 2);
                            cur_addr_q <= req_i.addr;
                            cur_idx_q  <= req_idx_c;
                            rem_q      <= req_beats_c;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state        <= S_BURST;
                        resp_o.valid <= 1'b1;
                        resp_o.addr  <= cur_addr_q;
                        resp_o.rdata <= beat_rdata_c;
                        cur_addr_q   <= cur_addr_q + 32'd4;
                        cur_idx_q    <= cur_idx_q + IDX_W'(1);
                        rem_q        <= rem_q - LEN_WIDTH'(1);
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                S_BURST: begin
                    if (rem_q != '0) begin
                        resp_o.valid <= 1'b1;
                        resp_o.addr  <= cur_addr_q;
                        resp_o.rdata <= beat_rdata_c;
                        cur_addr_q   <= cur_addr_q + 32'd4;
                        cur_idx_q    <= cur_idx_q + IDX_W'(1);
                        rem_q        <= rem_q - LEN_WIDTH'(1);
                    end else begin
                        state       <= S_IDLE;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    // Write commit on the edge closing the write's response beat; reset discards it.
    always_ff @(posedge clk) begin
        if (rst_n && (state == S_BURST) && wr_q) begin
            mem[base_idx_q] <= wdata_q;
        end
    end

endmodule : nmcu_mem_model
